// File: rtl/vga_pkg.sv
// Shared definitions for the RLE pixel encoder and the instruction decoder.
// The instr_t field order defined here is the single source of truth for both ends.
package vga_pkg;

    localparam int RUN_LEN_W = 10;
    localparam int COLOUR_W  = 8;
    localparam int INSTR_W   = RUN_LEN_W + COLOUR_W;
    localparam int MAX_RUN   = (1 << RUN_LEN_W) - 1;

    typedef struct packed {
        logic [RUN_LEN_W-1:0] run_len;
        logic [COLOUR_W-1:0]  rgb;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } enc_state_t;

    function automatic instr_t make_instr(input logic [RUN_LEN_W-1:0] len,
                                          input logic [COLOUR_W-1:0]  rgb);
        instr_t word;
        word.run_len = len;
        word.rgb     = rgb;
        return word;
    endfunction

endpackage

// File: rtl/rle_pixel_encoder_slice.sv
// Single-entry valid/ready output register for encoded instructions, plus a
// free-running count of words accepted downstream.
module instr_out_slice
    import vga_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [15:0]  count
);

    logic         valid_reg;
    logic [W-1:0] data_reg;
    logic [15:0]  count_reg;

    // The parent only loads when the slot is empty or draining, so a load
    // never overwrites a word the consumer has not yet taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (valid_reg && ready) begin
                count_reg <= count_reg + 16'd1;
            end
            if (load) begin
                valid_reg <= 1'b1;
                data_reg  <= din;
            end else if (ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign valid = valid_reg;
    assign dout  = data_reg;
    assign count = count_reg;

endmodule

// File: rtl/rle_pixel_encoder.sv
// Run-length encoder: turns a line-delimited RGB332 pixel stream into
// {run_len, rgb} instructions; runs stop at line ends and at the maximum length.
module rle_pixel_encoder #(
    parameter int LEN_W    = vga_pkg::RUN_LEN_W,
    parameter int COLOUR_W = vga_pkg::COLOUR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [COLOUR_W-1:0]       pix_rgb,
    input  logic                      pix_eol,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [LEN_W+COLOUR_W-1:0] instr,
    output logic [15:0]               instr_count
);

    localparam int INSTR_W = LEN_W + COLOUR_W;
    localparam logic [LEN_W-1:0] MAX_RUN = '1;
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    vga_pkg::enc_state_t  state_reg;
    logic [LEN_W-1:0]     cur_len_reg;
    logic [COLOUR_W-1:0]  cur_rgb_reg;
    logic [INSTR_W-1:0]   pending_reg;

    logic                 slot_free;
    logic                 accept;
    logic                 same_colour;
    logic                 at_max;
    logic                 emit;
    logic [INSTR_W-1:0]   emit_word;

    assign slot_free   = !instr_valid || instr_ready;
    assign pix_ready   = (state_reg != vga_pkg::ST_FLUSH) && slot_free;
    assign accept      = pix_valid && pix_ready;
    assign same_colour = (pix_rgb == cur_rgb_reg);
    assign at_max      = (cur_len_reg == MAX_RUN);

    always_comb begin
        emit      = 1'b0;
        emit_word = '0;
        case (state_reg)
            vga_pkg::ST_IDLE: begin
                if (accept && pix_eol) begin
                    emit      = 1'b1;
                    emit_word = {ONE, pix_rgb};
                end
            end
            vga_pkg::ST_RUN: begin
                if (accept) begin
                    if (same_colour && !at_max) begin
                        if (pix_eol) begin
                            emit      = 1'b1;
                            emit_word = {cur_len_reg + ONE, cur_rgb_reg};
                        end
                    end else begin
                        emit      = 1'b1;
                        emit_word = {cur_len_reg, cur_rgb_reg};
                    end
                end
            end
            vga_pkg::ST_FLUSH: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    emit_word = pending_reg;
                end
            end
            default: begin
                emit      = 1'b0;
                emit_word = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= vga_pkg::ST_IDLE;
            cur_len_reg <= '0;
            cur_rgb_reg <= '0;
            pending_reg <= '0;
        end else begin
            case (state_reg)
                vga_pkg::ST_IDLE: begin
                    if (accept && !pix_eol) begin
                        cur_rgb_reg <= pix_rgb;
                        cur_len_reg <= ONE;
                        state_reg   <= vga_pkg::ST_RUN;
                    end
                end
                vga_pkg::ST_RUN: begin
                    if (accept) begin
                        if (same_colour && !at_max) begin
                            if (pix_eol) begin
                                state_reg <= vga_pkg::ST_IDLE;
                            end else begin
                                cur_len_reg <= cur_len_reg + ONE;
                            end
                        end else if (pix_eol) begin
                            // Slot is taken by the broken run; park the single eol pixel.
                            pending_reg <= {ONE, pix_rgb};
                            state_reg   <= vga_pkg::ST_FLUSH;
                        end else begin
                            cur_rgb_reg <= pix_rgb;
                            cur_len_reg <= ONE;
                        end
                    end
                end
                vga_pkg::ST_FLUSH: begin
                    if (slot_free) begin
                        state_reg <= vga_pkg::ST_IDLE;
                    end
                end
                default: state_reg <= vga_pkg::ST_IDLE;
            endcase
        end
    end

    instr_out_slice #(
        .W(INSTR_W)
    ) u_slice (
        .clk   (clk),
        .rst   (rst),
        .load  (emit),
        .din   (emit_word),
        .ready (instr_ready),
        .valid (instr_valid),
        .dout  (instr),
        .count (instr_count)
    );

endmodule
